// File: rtl/data_ram_responder_pkg.sv
// Shared definitions for the MEM-stage data RAM: lane-mask encodings, clear-engine
// states and the lane-mask legality check.
package data_ram_responder_pkg;

    localparam logic [3:0] SEL_WORD    = 4'b1111;
    localparam logic [3:0] SEL_HI_HALF = 4'b1100;
    localparam logic [3:0] SEL_LO_HALF = 4'b0011;
    localparam logic [3:0] SEL_B0      = 4'b0001;
    localparam logic [3:0] SEL_B1      = 4'b0010;
    localparam logic [3:0] SEL_B2      = 4'b0100;
    localparam logic [3:0] SEL_B3      = 4'b1000;
    localparam logic [3:0] SEL_NONE    = 4'b0000;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic logic sel_legal(input logic [3:0] sel);
        case (sel)
            SEL_WORD, SEL_HI_HALF, SEL_LO_HALF,
            SEL_B0, SEL_B1, SEL_B2, SEL_B3, SEL_NONE: sel_legal = 1'b1;
            default:                                  sel_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_ram_responder_ram_lane_unit.sv
// Lane steering for the data RAM: byte enables and merged store word on the write
// side, lane extraction with zero/sign extension on the read side.
module ram_lane_unit
    import data_ram_responder_pkg::*;
(
    input  logic [3:0]  sel,
    input  logic [31:0] data_in,
    input  logic [31:0] stored,
    input  logic        extend_type,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word,
    output logic [31:0] rd_data
);

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        ext_half = {{16{sgn & h[15]}}, h};
    endfunction

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        ext_byte = {{24{sgn & b[7]}}, b};
    endfunction

    logic [31:0] placed;

    always_comb begin
        placed  = '0;
        rd_data = '0;
        byte_en = sel_legal(sel) ? sel : SEL_NONE;
        case (sel)
            SEL_WORD: begin
                placed  = data_in;
                rd_data = stored;
            end
            SEL_HI_HALF: begin
                placed  = {data_in[15:0], 16'h0000};
                rd_data = ext_half(stored[31:16], extend_type);
            end
            SEL_LO_HALF: begin
                placed  = {16'h0000, data_in[15:0]};
                rd_data = ext_half(stored[15:0], extend_type);
            end
            SEL_B0: begin
                placed  = {24'h0, data_in[7:0]};
                rd_data = ext_byte(stored[7:0], extend_type);
            end
            SEL_B1: begin
                placed  = {16'h0, data_in[7:0], 8'h0};
                rd_data = ext_byte(stored[15:8], extend_type);
            end
            SEL_B2: begin
                placed  = {8'h0, data_in[7:0], 16'h0};
                rd_data = ext_byte(stored[23:16], extend_type);
            end
            SEL_B3: begin
                placed  = {data_in[7:0], 24'h0};
                rd_data = ext_byte(stored[31:24], extend_type);
            end
            default: ;
        endcase
        // Unselected lanes keep the stored bytes so the array write is a plain word write.
        wr_word = stored;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) wr_word[8*i +: 8] = placed[8*i +: 8];
        end
    end

endmodule

// File: rtl/data_ram_responder.sv
// MEM-stage data RAM: combinational lane-aware read, masked synchronous write,
// post-reset clear engine, sticky illegal-mask flag and registered debug port.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-3:0] ram_addr,
    input  logic [31:0]          ram_data_in,
    input  logic [3:0]           ram_sel,
    input  logic                 ram_rw,
    input  logic                 ram_extend_type,
    output logic [31:0]          ram_data_out,
    input  logic                 clr_req,
    output logic                 ram_busy,
    output logic                 sel_err,
    input  logic [ADDR_BITS-3:0] dbg_addr,
    output logic [31:0]          dbg_data
);

    localparam int WORD_BITS = ADDR_BITS - 2;
    localparam int DEPTH     = 1 << WORD_BITS;

    logic [31:0]          mem [DEPTH];
    state_t               state;
    logic [WORD_BITS-1:0] clr_cnt;
    logic [31:0]          stored;
    logic [31:0]          wr_word;
    logic [31:0]          lane_rd;
    logic [3:0]           byte_en;
    logic                 busy;
    logic                 wr_en;

    assign stored = mem[ram_addr];

    ram_lane_unit u_lane (
        .sel         (ram_sel),
        .data_in     (ram_data_in),
        .stored      (stored),
        .extend_type (ram_extend_type),
        .byte_en     (byte_en),
        .wr_word     (wr_word),
        .rd_data     (lane_rd)
    );

    assign busy         = (state == CLEAR);
    assign ram_busy     = busy;
    assign ram_data_out = busy ? 32'h0 : lane_rd;
    // A clear request in the same cycle as a store drops the store.
    assign wr_en        = ram_rw && !busy && !clr_req && (byte_en != SEL_NONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            sel_err  <= 1'b0;
            dbg_data <= 32'h0;
        end else begin
            dbg_data <= mem[dbg_addr];
            if (ram_rw && !sel_legal(ram_sel)) sel_err <= 1'b1;
            case (state)
                CLEAR: begin
                    if (clr_cnt == '1) state <= READY;
                    else               clr_cnt <= clr_cnt + 1'b1;
                end
                READY: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy)       mem[clr_cnt]  <= 32'h0;
            else if (wr_en) mem[ram_addr] <= wr_word;
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder with a cycle-stamped scoreboard queue.
module tb_data_ram_responder;

    localparam int ADDR_BITS = 12;
    localparam int DEPTH     = 1 << (ADDR_BITS - 2);

    localparam int K_DOUT = 0;
    localparam int K_DBG  = 1;
    localparam int K_BUSY = 2;
    localparam int K_SERR = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [ADDR_BITS-3:0] ram_addr;
    logic [31:0]          ram_data_in;
    logic [3:0]           ram_sel;
    logic                 ram_rw;
    logic                 ram_extend_type;
    logic [31:0]          ram_data_out;
    logic                 clr_req;
    logic                 ram_busy;
    logic                 sel_err;
    logic [ADDR_BITS-3:0] dbg_addr;
    logic [31:0]          dbg_data;

    data_ram_responder #(.ADDR_BITS(ADDR_BITS)) dut (
        .clk             (clk),
        .rst             (rst),
        .ram_addr        (ram_addr),
        .ram_data_in     (ram_data_in),
        .ram_sel         (ram_sel),
        .ram_rw          (ram_rw),
        .ram_extend_type (ram_extend_type),
        .ram_data_out    (ram_data_out),
        .clr_req         (clr_req),
        .ram_busy        (ram_busy),
        .sel_err         (sel_err),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;

    always @(posedge clk) cyc++;

    // Monitor: at each falling edge, check every expectation stamped for this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
                K_DOUT:  act = ram_data_out;
                K_DBG:   act = dbg_data;
                K_BUSY:  act = {31'h0, ram_busy};
                default: act = {31'h0, sel_err};
            endcase
            total++;
            if (act !== e.exp || e.cyc != cyc)
                $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", e.name, act, e.exp, cyc);
            else
                passed++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input int kind, input string name, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.name = name;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic write(input logic [ADDR_BITS-3:0] a, input logic [3:0] s, input logic [31:0] d);
        ram_addr    = a;
        ram_sel     = s;
        ram_data_in = d;
        ram_rw      = 1'b1;
        tick();
        ram_rw      = 1'b0;
    endtask

    task automatic read_chk(input logic [ADDR_BITS-3:0] a, input logic [3:0] s, input logic ext,
                            input string name, input logic [31:0] v);
        ram_addr        = a;
        ram_sel         = s;
        ram_extend_type = ext;
        ram_rw          = 1'b0;
        expect_val(K_DOUT, name, v);
        tick();
    endtask

    task automatic dbg_chk(input logic [ADDR_BITS-3:0] a, input string name, input logic [31:0] v);
        dbg_addr = a;
        tick();
        expect_val(K_DBG, name, v);
    endtask

    initial begin
        rst = 1'b1; ram_addr = '0; ram_data_in = '0; ram_sel = 4'b0000; ram_rw = 1'b0;
        ram_extend_type = 1'b0; clr_req = 1'b0; dbg_addr = '0;
        tick();
        tick();
        expect_val(K_BUSY, "reset_busy", 32'h1);
        expect_val(K_SERR, "reset_sel_err", 32'h0);
        expect_val(K_DBG,  "reset_dbg", 32'h0);
        rst = 1'b0;

        // Initial clear: busy for exactly DEPTH cycles; late stores must be ignored.
        for (int i = 0; i < DEPTH; i++) begin
            expect_val(K_BUSY, "init_busy", 32'h1);
            if (i >= DEPTH - 24) begin
                ram_addr    = (i % 2 == 0) ? 10'd5 : 10'd9;
                ram_sel     = 4'b1111;
                ram_data_in = 32'hDEAD_BEEF;
                ram_rw      = 1'b1;
                expect_val(K_DOUT, "busy_read_zero", 32'h0);
            end
            tick();
        end
        ram_rw = 1'b0;
        expect_val(K_BUSY, "init_busy_fall", 32'h0);

        dbg_chk(10'd0,    "dbg_clr_0",    32'h0);
        dbg_chk(10'd511,  "dbg_clr_511",  32'h0);
        dbg_chk(10'd1023, "dbg_clr_1023", 32'h0);
        read_chk(10'd5, 4'b1111, 1'b0, "busy_write_lost_5", 32'h0);
        read_chk(10'd9, 4'b1111, 1'b0, "busy_write_lost_9", 32'h0);

        write(10'd5, 4'b1111, 32'h8123_F0A5);
        read_chk(10'd5, 4'b1111, 1'b0, "rd_word",      32'h8123_F0A5);
        read_chk(10'd5, 4'b1100, 1'b1, "rd_hi_sext",   32'hFFFF_8123);
        read_chk(10'd5, 4'b0011, 1'b0, "rd_lo_zext",   32'h0000_F0A5);
        read_chk(10'd5, 4'b1000, 1'b1, "rd_b3_sext",   32'hFFFF_FF81);
        read_chk(10'd5, 4'b1000, 1'b0, "rd_b3_zext",   32'h0000_0081);
        read_chk(10'd5, 4'b0001, 1'b1, "rd_b0_sext",   32'hFFFF_FFA5);
        read_chk(10'd5, 4'b0010, 1'b1, "rd_b1_sext",   32'hFFFF_FFF0);
        read_chk(10'd5, 4'b0100, 1'b1, "rd_b2_sext",   32'h0000_0023);
        read_chk(10'd5, 4'b0011, 1'b1, "rd_lo_sext",   32'hFFFF_F0A5);
        read_chk(10'd5, 4'b0000, 1'b0, "rd_idle",      32'h0);

        write(10'd5, 4'b0100, 32'h0000_00EE);
        read_chk(10'd5, 4'b1111, 1'b0, "byte_merge",   32'h81EE_F0A5);
        write(10'd5, 4'b0011, 32'h0000_1234);
        read_chk(10'd5, 4'b1111, 1'b0, "half_merge",   32'h81EE_1234);
        write(10'd5, 4'b1100, 32'hFFFF_5678);
        read_chk(10'd5, 4'b1111, 1'b0, "hi_half_merge", 32'h5678_1234);

        // Illegal lane mask: store suppressed, sticky flag from the next cycle.
        write(10'd7, 4'b1111, 32'h7777_7777);
        ram_addr = 10'd7; ram_sel = 4'b0101; ram_data_in = 32'hFFFF_FFFF; ram_rw = 1'b1;
        expect_val(K_DOUT, "illegal_read_zero", 32'h0);
        expect_val(K_SERR, "sel_err_before", 32'h0);
        tick();
        ram_rw = 1'b0;
        expect_val(K_SERR, "sel_err_set", 32'h1);
        read_chk(10'd7, 4'b1111, 1'b0, "illegal_no_write", 32'h7777_7777);
        expect_val(K_SERR, "sel_err_held", 32'h1);

        // Debug port sees the old word when a store hits the same address.
        write(10'd9, 4'b1111, 32'h1111_1111);
        dbg_addr = 10'd9;
        write(10'd9, 4'b1111, 32'h2222_2222);
        expect_val(K_DBG, "dbg_rbw_old", 32'h1111_1111);
        tick();
        expect_val(K_DBG, "dbg_rbw_new", 32'h2222_2222);

        // Clear request beats a simultaneous store; a second request mid-clear is ignored.
        ram_addr = 10'd3; ram_sel = 4'b1111; ram_data_in = 32'hAAAA_5555; ram_rw = 1'b1; clr_req = 1'b1;
        expect_val(K_BUSY, "clr_busy_before", 32'h0);
        tick();
        ram_rw = 1'b0; clr_req = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            expect_val(K_BUSY, "reclr_busy", 32'h1);
            clr_req = (i == 500);
            tick();
        end
        clr_req = 1'b0;
        expect_val(K_BUSY, "reclr_busy_fall", 32'h0);
        read_chk(10'd3, 4'b1111, 1'b0, "clr_write_lost", 32'h0);
        read_chk(10'd5, 4'b1111, 1'b0, "reclr_zero_5",   32'h0);
        read_chk(10'd7, 4'b1111, 1'b0, "reclr_zero_7",   32'h0);
        read_chk(10'd9, 4'b1111, 1'b0, "reclr_zero_9",   32'h0);
        dbg_chk(10'd1023, "reclr_dbg_1023", 32'h0);
        expect_val(K_SERR, "sel_err_sticky", 32'h1);
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_val(K_SERR, "sel_err_rst", 32'h0);
        expect_val(K_BUSY, "rst_busy", 32'h1);
        tick();

        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            total++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
